// File: rtl/alu_8bit_pkg.sv
// Shared opcode encodings for the 8-bit ALU and its datapath core.
package alu_8bit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational ALU datapath: result and carry/borrow/shift-out for every opcode.
module alu_8bit_core
  import alu_8bit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  s,
  output logic [WIDTH-1:0] next_y,
  output logic             next_carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // One extra bit holds the carry out of the add and the borrow out of the subtract
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    next_y     = '0;
    next_carry = 1'b0;
    case (s)
      OP_ADD: {next_carry, next_y} = w_sum;
      OP_SUB: {next_carry, next_y} = w_diff;
      OP_AND: next_y = A & B;
      OP_OR:  next_y = A | B;
      OP_XOR: next_y = A ^ B;
      OP_NOT: next_y = ~A;
      OP_SHL: begin
        next_y     = {A[WIDTH-2:0], 1'b0};
        next_carry = A[WIDTH-1];
      end
      OP_SHR: begin
        next_y     = {1'b0, A[WIDTH-1:1]};
        next_carry = A[0];
      end
      default: begin
        next_y     = '0;
        next_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// 8-bit ALU top: the core result is registered once per clk edge, cleared by async reset.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH-1:0] w_next_y;
  logic             w_next_carry;

  alu_8bit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .A         (A),
    .B         (B),
    .s         (s),
    .next_y    (w_next_y),
    .next_carry(w_next_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      carry <= 1'b0;
    end else begin
      y     <= w_next_y;
      carry <= w_next_carry;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed and random checks of alu_8bit with hand-computed expectations and a reference model.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic [7:0] y;
  logic       carry;

  int n_checks;
  int n_fail;

  alu_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a),
    .B    (b),
    .s    (op),
    .y    (y),
    .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp_y, input logic exp_c);
    n_checks++;
    assert (y === exp_y && carry === exp_c)
    else begin
      n_fail++;
      $error("FAIL %s: observed y=%0d carry=%0b, expected y=%0d carry=%0b",
             tag, y, carry, exp_y, exp_c);
    end
  endtask

  // Drive operands, let one edge register them, then sample just after the edge
  task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                       input logic [7:0] exp_y, input logic exp_c, input string tag);
    a  = ta;
    b  = tb;
    op = ts;
    @(posedge clk);
    #1;
    check(tag, exp_y, exp_c);
  endtask

  function automatic logic [8:0] ref_alu(input int ia, input int ib, input int is);
    int ry;
    int rc;
    ry = 0;
    rc = 0;
    case (is)
      0: begin ry = (ia + ib) % 256; rc = (ia + ib > 255) ? 1 : 0; end
      1: begin ry = (ia - ib + 256) % 256; rc = (ia < ib) ? 1 : 0; end
      2: ry = ia & ib;
      3: ry = ia | ib;
      4: ry = ia ^ ib;
      5: ry = 255 - ia;
      6: begin ry = (ia * 2) % 256; rc = (ia >= 128) ? 1 : 0; end
      default: begin ry = ia / 2; rc = ia % 2; end
    endcase
    return {rc[0], ry[7:0]};
  endfunction

  logic [8:0] exp_v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    a        = 8'd0;
    b        = 8'd0;
    op       = 3'd0;

    #1 rst_n = 1'b0;
    #1 check("reset_async", 8'd0, 1'b0);

    // Inputs that would give a nonzero result must not reach the outputs while in reset
    a  = 8'd200;
    b  = 8'd100;
    op = 3'b000;
    repeat (2) @(posedge clk);
    #1 check("reset_held", 8'd0, 1'b0);

    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_edge_after_reset", 8'd44, 1'b1);

    apply(8'd10, 8'd10, 3'b000, 8'd20,  1'b0, "sweep_add");
    apply(8'd10, 8'd10, 3'b001, 8'd0,   1'b0, "sweep_sub");
    apply(8'd10, 8'd10, 3'b010, 8'd10,  1'b0, "sweep_and");
    apply(8'd10, 8'd10, 3'b011, 8'd10,  1'b0, "sweep_or");
    apply(8'd10, 8'd10, 3'b100, 8'd0,   1'b0, "sweep_xor");
    apply(8'd10, 8'd10, 3'b101, 8'd245, 1'b0, "sweep_not");
    apply(8'd10, 8'd10, 3'b110, 8'd20,  1'b0, "sweep_shl");
    apply(8'd10, 8'd10, 3'b111, 8'd5,   1'b0, "sweep_shr");

    apply(8'd200, 8'd100, 3'b000, 8'd44, 1'b1, "add_ovf");
    apply(8'd255, 8'd1,   3'b000, 8'd0,  1'b1, "add_wrap");
    apply(8'd5,   8'd10,  3'b001, 8'd251, 1'b1, "sub_borrow");
    apply(8'd10,  8'd5,   3'b001, 8'd5,  1'b0, "sub_noborrow");
    apply(8'h81,  8'h00,  3'b110, 8'h02, 1'b1, "shl_out");
    apply(8'h81,  8'h00,  3'b111, 8'h40, 1'b1, "shr_out");
    apply(8'hF0,  8'h3C,  3'b010, 8'h30, 1'b0, "and_mix");
    apply(8'hF0,  8'h3C,  3'b011, 8'hFC, 1'b0, "or_mix");
    apply(8'hF0,  8'h3C,  3'b100, 8'hCC, 1'b0, "xor_mix");
    apply(8'h5A,  8'hFF,  3'b101, 8'hA5, 1'b0, "not_ignores_b");

    // Carry must clear on a logic op right after a carry-producing op
    apply(8'd255, 8'd255, 3'b000, 8'd254, 1'b1, "add_max");
    apply(8'd255, 8'd255, 3'b010, 8'd255, 1'b0, "and_clears_carry");

    // Output must hold until the edge, then reflect only the new inputs
    apply(8'd10, 8'd10, 3'b000, 8'd20, 1'b0, "pre_midreset");
    a  = 8'd1;
    op = 3'b001;
    #2 check("hold_between_edges", 8'd20, 1'b0);
    a  = 8'd10;
    op = 3'b000;
    rst_n = 1'b0;
    #1 check("midcycle_reset", 8'd0, 1'b0);
    #1 rst_n = 1'b1;
    #1 check("reset_release_no_edge", 8'd0, 1'b0);
    @(posedge clk);
    #1 check("restore_after_reset", 8'd20, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 7));
      exp_v = ref_alu(int'(a), int'(b), int'(op));
      @(posedge clk);
      #1 check("random", exp_v[7:0], exp_v[8]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; all values below are for WIDTH=8.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all registers.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: A  input  WIDTH  operand A, unsigned.
REQ-006 Port: B  input  WIDTH  operand B, unsigned.
REQ-007 Port: s  input  3  operation select.
REQ-008 Port: y  output  WIDTH  registered result.
REQ-009 Port: carry  output  1  registered carry/borrow/shift-out flag.

Function
REQ-010 The block SHALL compute the result combinationally from A, B and s, and register y and carry on every rising clk edge (no enable).
- Latency: exactly 1 cycle.
- Inputs sampled at edge N appear on y/carry after edge N.
REQ-011 s=000 ADD: {carry,y} SHALL equal A+B as a 9-bit sum; carry=1 on unsigned overflow.
REQ-012 s=001 SUB: y SHALL equal (A-B) mod 256; carry SHALL be the borrow (1 iff A<B).
REQ-013 s=010 AND: y=A&B; carry=0.
REQ-014 s=011 OR: y=A|B; carry=0.
REQ-015 s=100 XOR: y=A^B; carry=0.
REQ-016 s=101 NOT: y=~A; B ignored; carry=0.
REQ-017 s=110 SHL: y={A[6:0],0}; carry=A[7].
REQ-018 s=111 SHR (logical): y={0,A[7:1]}; carry=A[0].
REQ-019 All 8 codes are defined; there is no illegal opcode.
REQ-020 An opcode or operand change SHALL affect only the next registered result; no state is carried between operations.
REQ-021 Inputs containing X/Z need no defined behaviour, but the outputs SHALL be 0 until the first post-reset edge.

Reset
REQ-022 While rst_n=0, y SHALL be 0 and carry SHALL be 0, immediately and independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard the pending result; there is no other state.
REQ-024 After rst_n deasserts, the first rising edge SHALL register the result of the current inputs.

Structure
REQ-025 Opcode constants (OP_ADD=000 ... OP_SHR=111) SHALL reside in the shared package alu_8bit_pkg.
REQ-026 The combinational datapath SHALL be the sub-module alu_8bit_core (inputs A, B, s; outputs next_y, next_carry).
REQ-027 The top level SHALL contain only the output registers.

Verification
REQ-028 A=10, B=10, sweep s=000..111, one op per cycle -> y=20,0,10,10,0,245,20,5 and carry=0 throughout, each 1 cycle after apply.
REQ-029 ADD overflow: A=200, B=100, s=000 -> y=44, carry=1; A=255, B=1 -> y=0, carry=1.
REQ-030 SUB borrow: A=5, B=10, s=001 -> y=251, carry=1; A=10, B=5 -> y=5, carry=0.
REQ-031 Shifts: A=8'h81, s=110 -> y=8'h02, carry=1; s=111 -> y=8'h40, carry=1.
REQ-032 Reset: drive rst_n=0 between clock edges while y=20 -> y=0 and carry=0 immediately; release -> next edge restores the correct result.
REQ-033 Random: 1000 cycles of random A, B, s compared against a reference model with 1-cycle delay -> zero mismatches.
